native_to_axi4_master: RTL and testbench
========================================

// Module: native_to_axi4_master
// PURPOSE
// - Turns DDR-IP native app-interface commands (app_en/app_cmd/app_addr, app_wdf_*) into single-beat AXI4 master transactions.
// - Read responses return on app_rd_data*; the block is the converse of our AXI4-slave-to-native DDR bridge.
// - Lets native-interface clients (test engines, legacy DMA) drive any AXI4 memory or interconnect.
// - One command in flight; the write-data path is buffered.
// PARAMETERS
// - ADDR_WIDTH      27   app_addr width
// - DATA_WIDTH      256  app/AXI data width; 256 or 512
// - AXI_ADDR_WIDTH  32   axi_awaddr/axi_araddr width; must be >= ADDR_WIDTH+ADDR_SHIFT
// - ADDR_SHIFT      0    axi address = app_addr << ADDR_SHIFT, zero-extended
// - ID_VALUE        0    constant axi_awid/axi_arid
// - WDF_DEPTH       4    write-data FIFO depth, power of 2
// PORTS
// - clock                input   1              single clock; axi_inf.axi_aclk is driven from it
// - rst                  input   1              asynchronous, active-high reset
// - app_addr             input   ADDR_WIDTH     command address
// - app_cmd              input   3              3'b000 write, 3'b001 read, others illegal
// - app_en               input   1              command valid
// - app_rdy              output  1              command accept; a command is taken when app_en && app_rdy
// - app_wdf_data         input   DATA_WIDTH     write data
// - app_wdf_mask         input   DATA_WIDTH/8   1 = byte masked
// - app_wdf_wren         input   1              write-data valid
// - app_wdf_end          input   1              ignored; always single beat
// - app_wdf_rdy          output  1              write-data accept
// - app_rd_data          output  DATA_WIDTH     read data
// - app_rd_data_valid    output  1              1-cycle strobe per read
// - app_rd_data_end      output  1              equals app_rd_data_valid
// - init_calib_complete  output  1              high from the first cycle after reset release
// - resp_err             output  1              sticky; set by any BRESP/RRESP != 2'b00
// - axi_inf              modport  axi_inf.master  AXI4 master; all outputs registered
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, FIFO empty. Reset mid-transaction abandons it: valids drop asynchronously, no response is issued.
// - app_wdf_rdy = !wdf_full. Write data may precede its command; the FIFO pairs data with commands in order.
// - FSM states:
//   - IDLE: app_rdy = init_calib_complete && (cmd!=write || !wdf_empty). On accept, latch addr/cmd.
//     - write -> WR_AW; read -> RD_AR; illegal cmd -> dropped, stay IDLE.
//   - WR_AW: axi_awvalid and axi_wvalid asserted the next cycle, together.
//     - wdata = FIFO head; wstrb = ~mask; wlast = 1; awlen = 0; awsize = log2(DATA_WIDTH/8); awburst = INCR.
//     - Each valid drops the cycle after its own handshake, independently. FIFO pops on the W handshake.
//     - Both done -> WR_B.
//   - WR_B: bready = 1; on bvalid -> IDLE; latch resp_err if bresp != 0.
//   - RD_AR: arvalid until arready; arlen = 0 -> RD_R.
//   - RD_R: rready = 1. On rvalid, register rdata; app_rd_data_valid pulses 1 cycle later -> IDLE.
//     - Read latency is 1 clock after the R handshake.
// - app_rdy is low outside IDLE, so back-to-back commands are spaced by at least 1 IDLE cycle.
// - FIFO full and wren in the same cycle: the beat is not taken (rdy low). Simultaneous push and pop is allowed when non-empty.
// - Pointers are log2(WDF_DEPTH)+1 bits wide and wrap naturally; full = MSBs differ and LSBs equal.
// - Widths: AXI address = {zero pad, app_addr, ADDR_SHIFT zeros}; no address increment (single beat).
// - axi_bid/axi_rid are ignored.
// STRUCTURE
// - Package native_axi_pkg: APP_CMD_WR/APP_CMD_RD localparams; n2a_state_e {IDLE,WR_AW,WR_B,RD_AR,RD_R}; AXI BURST_INCR/RESP_OKAY constants.
// - Sub-module n2a_wdf_fifo: sync FIFO, width DATA_WIDTH+DATA_WIDTH/8, depth WDF_DEPTH, async reset, full/empty flags. The FSM and AXI drive live in the top.
// TESTING
// - Write: preload wdf 0xA5.., mask 0; app_cmd=000 addr=0x100 -> awaddr 0x100, wstrb all-ones, wdata match, bready taken, app_rdy back after bvalid.
// - Read: cmd=001 addr=0x40; slave returns rdata 0xDEAD.. after 5 cycles -> app_rd_data_valid 1 cycle, 1 clock after the R handshake, data matches, end=1.
// - Data ahead of command: push 4 beats (full, app_wdf_rdy=0), then 4 write commands -> 4 AW/W pairs in order, FIFO empty at end.
// - Decoupled handshake: awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held; a single B is accepted.
// - Error: bresp=2'b10 -> resp_err=1 and stays set; subsequent OKAY responses keep it 1 until rst.
// - Reset mid-read (rst pulse during RD_R) -> all valids 0 immediately; after release, app_rdy=1 and no stale app_rd_data_valid appears.

Source files
------------

// File: rtl/native_axi_pkg.sv
// Shared command codes, FSM state type and AXI constants for the native-to-AXI4 bridge.
package native_axi_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW,
    WR_B,
    RD_AR,
    RD_R
  } n2a_state_e;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle with master/slave views; axi_aclk is sourced by the master side.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
);
  logic                      axi_aclk;

  logic [ID_WIDTH-1:0]       axi_awid;
  logic [ADDR_WIDTH-1:0]     axi_awaddr;
  logic [7:0]                axi_awlen;
  logic [2:0]                axi_awsize;
  logic [1:0]                axi_awburst;
  logic                      axi_awvalid;
  logic                      axi_awready;

  logic [DATA_WIDTH-1:0]     axi_wdata;
  logic [DATA_WIDTH/8-1:0]   axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;

  logic [ID_WIDTH-1:0]       axi_bid;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  logic [ID_WIDTH-1:0]       axi_arid;
  logic [ADDR_WIDTH-1:0]     axi_araddr;
  logic [7:0]                axi_arlen;
  logic [2:0]                axi_arsize;
  logic [1:0]                axi_arburst;
  logic                      axi_arvalid;
  logic                      axi_arready;

  logic [ID_WIDTH-1:0]       axi_rid;
  logic [DATA_WIDTH-1:0]     axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rlast;
  logic                      axi_rvalid;
  logic                      axi_rready;

  modport master (
    output axi_aclk,
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_aclk,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );
endinterface

// File: rtl/n2a_wdf_fifo.sv
// Write-data FIFO: holds {mask, data} beats until the matching write command drains them.
module n2a_wdf_fifo #(
  parameter int WIDTH = 288,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q[PW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (PW+1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/native_to_axi4_master.sv
// Native DDR app-interface to single-beat AXI4 master, one command in flight.
module native_to_axi4_master
  import native_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ADDR_SHIFT     = 0,
  parameter int ID_VALUE       = 0,
  parameter int WDF_DEPTH      = 4,
  parameter int ID_WIDTH       = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    resp_err,
  axi4_if.master                  axi_inf
);
  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] AXSIZE     = 3'($clog2(STRB_WIDTH));

  n2a_state_e                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      bready_q, bready_d;
  logic                      rready_q, rready_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      calib_q;
  logic                      err_q, err_d;

  logic                      wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [DATA_WIDTH-1:0]     wdf_data;
  logic [STRB_WIDTH-1:0]     wdf_mask;
  logic                      cmd_accept;
  logic                      unused_inputs;

  n2a_wdf_fifo #(
    .WIDTH (DATA_WIDTH + STRB_WIDTH),
    .DEPTH (WDF_DEPTH)
  ) u_wdf (
    .clk     (clock),
    .rst     (rst),
    .push_i  (wdf_push),
    .pop_i   (wdf_pop),
    .din_i   ({app_wdf_mask, app_wdf_data}),
    .dout_o  ({wdf_mask, wdf_data}),
    .full_o  (wdf_full),
    .empty_o (wdf_empty)
  );

  assign app_wdf_rdy = calib_q && !wdf_full;
  assign wdf_push    = app_wdf_wren && app_wdf_rdy;
  assign app_rdy     = (state_q == IDLE) && calib_q && ((app_cmd != APP_CMD_WR) || !wdf_empty);
  assign cmd_accept  = app_en && app_rdy;

  assign app_rd_data         = rdata_q;
  assign app_rd_data_valid   = rd_valid_q;
  assign app_rd_data_end     = rd_valid_q;
  assign init_calib_complete = calib_q;
  assign resp_err            = err_q;

  assign axi_inf.axi_aclk    = clock;
  assign axi_inf.axi_awid    = ID_WIDTH'(ID_VALUE);
  assign axi_inf.axi_awaddr  = addr_q;
  assign axi_inf.axi_awlen   = '0;
  assign axi_inf.axi_awsize  = AXSIZE;
  assign axi_inf.axi_awburst = BURST_INCR;
  assign axi_inf.axi_awvalid = awvalid_q;
  assign axi_inf.axi_wdata   = wdata_q;
  assign axi_inf.axi_wstrb   = wstrb_q;
  assign axi_inf.axi_wlast   = wvalid_q;
  assign axi_inf.axi_wvalid  = wvalid_q;
  assign axi_inf.axi_bready  = bready_q;
  assign axi_inf.axi_arid    = ID_WIDTH'(ID_VALUE);
  assign axi_inf.axi_araddr  = addr_q;
  assign axi_inf.axi_arlen   = '0;
  assign axi_inf.axi_arsize  = AXSIZE;
  assign axi_inf.axi_arburst = BURST_INCR;
  assign axi_inf.axi_arvalid = arvalid_q;
  assign axi_inf.axi_rready  = rready_q;

  assign unused_inputs = ^{app_wdf_end, axi_inf.axi_bid, axi_inf.axi_rid, axi_inf.axi_rlast};

  // State and registered AXI/app outputs; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      calib_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      bready_q   <= bready_d;
      rready_q   <= rready_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      calib_q    <= 1'b1;
      err_q      <= err_d;
    end
  end

  // Next-state and handshake logic; AW and W valids retire independently.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    bready_d   = bready_q;
    rready_d   = rready_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    wdf_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d = AXI_ADDR_WIDTH'(app_addr) << ADDR_SHIFT;
          if (app_cmd == APP_CMD_WR) begin
            state_d   = WR_AW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = wdf_data;
            wstrb_d   = ~wdf_mask;
          end else if (app_cmd == APP_CMD_RD) begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW: begin
        if (awvalid_q && axi_inf.axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_inf.axi_wready) begin
          wvalid_d = 1'b0;
          wdf_pop  = 1'b1;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (axi_inf.axi_bvalid) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          if (axi_inf.axi_bresp != RESP_OKAY) err_d = 1'b1;
        end
      end
      RD_AR: begin
        if (axi_inf.axi_arready) begin
          state_d   = RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_R: begin
        if (axi_inf.axi_rvalid) begin
          state_d    = IDLE;
          rready_d   = 1'b0;
          rdata_d    = axi_inf.axi_rdata;
          rd_valid_d = 1'b1;
          if (axi_inf.axi_rresp != RESP_OKAY) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_native_to_axi4_master.sv
// Directed self-checking bench for native_to_axi4_master; the bench plays the AXI slave.
module tb_native_to_axi4_master;
  import native_axi_pkg::*;

  logic         clock = 1'b0;
  logic         rst   = 1'b1;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         resp_err;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clock = ~clock;

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .ID_WIDTH(4)) axi ();

  native_to_axi4_master #(
    .ADDR_WIDTH     (27),
    .DATA_WIDTH     (256),
    .AXI_ADDR_WIDTH (32),
    .ADDR_SHIFT     (0),
    .ID_VALUE       (0),
    .WDF_DEPTH      (4),
    .ID_WIDTH       (4)
  ) dut (
    .clock               (clock),
    .rst                 (rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .resp_err            (resp_err),
    .axi_inf             (axi)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic push_beat(input logic [255:0] d, input logic [31:0] m);
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    @(negedge clock);
    app_wdf_wren = 1'b0;
  endtask

  // Holds app_en until accepted (bounded); returns on the negedge after the accepting edge.
  task automatic issue_cmd(input logic [2:0] cmd, input logic [26:0] addr);
    bit ok = 1'b0;
    app_cmd  = cmd;
    app_addr = addr;
    app_en   = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (app_rdy) ok = 1'b1;
      @(negedge clock);
    end
    app_en  = 1'b0;
    app_cmd = APP_CMD_RD;
    check("cmd_accepted", 256'(ok), 256'd1);
  endtask

  // Write with AW/W ready already high; B returned with the given response.
  task automatic do_write(input logic [26:0] addr, input logic [255:0] data,
                          input logic [31:0] strb, input logic [1:0] resp);
    issue_cmd(APP_CMD_WR, addr);
    check("awvalid_up", 256'(axi.axi_awvalid), 256'd1);
    check("wvalid_up", 256'(axi.axi_wvalid), 256'd1);
    check("awaddr", 256'(axi.axi_awaddr), 256'(addr));
    check("wdata", axi.axi_wdata, data);
    check("wstrb", 256'(axi.axi_wstrb), 256'(strb));
    check("wlast", 256'(axi.axi_wlast), 256'd1);
    check("awlen", 256'(axi.axi_awlen), 256'd0);
    check("awsize", 256'(axi.axi_awsize), 256'd5);
    check("awburst", 256'(axi.axi_awburst), 256'd1);
    check("awid", 256'(axi.axi_awid), 256'd0);
    check("rdy_busy_wr", 256'(app_rdy), 256'd0);
    @(negedge clock);
    check("awvalid_drop", 256'(axi.axi_awvalid), 256'd0);
    check("wvalid_drop", 256'(axi.axi_wvalid), 256'd0);
    check("bready_up", 256'(axi.axi_bready), 256'd1);
    axi.axi_bvalid = 1'b1;
    axi.axi_bresp  = resp;
    @(negedge clock);
    axi.axi_bvalid = 1'b0;
    axi.axi_bresp  = 2'b00;
    check("bready_drop", 256'(axi.axi_bready), 256'd0);
    check("rdy_after_b", 256'(app_rdy), 256'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    logic [31:0]  m;

    app_addr = '0; app_cmd = APP_CMD_RD; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    axi.axi_awready = 1'b0; axi.axi_wready = 1'b0;
    axi.axi_bid = '0; axi.axi_bresp = 2'b00; axi.axi_bvalid = 1'b0;
    axi.axi_arready = 1'b0;
    axi.axi_rid = '0; axi.axi_rdata = '0; axi.axi_rresp = 2'b00;
    axi.axi_rlast = 1'b0; axi.axi_rvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_app_rdy", 256'(app_rdy), 256'd0);
    check("rst_wdf_rdy", 256'(app_wdf_rdy), 256'd0);
    check("rst_calib", 256'(init_calib_complete), 256'd0);
    check("rst_awvalid", 256'(axi.axi_awvalid), 256'd0);
    check("rst_arvalid", 256'(axi.axi_arvalid), 256'd0);
    check("rst_rd_valid", 256'(app_rd_data_valid), 256'd0);
    rst = 1'b0;
    @(negedge clock);
    check("calib_up", 256'(init_calib_complete), 256'd1);
    check("rdy_idle", 256'(app_rdy), 256'd1);
    check("wdf_rdy_idle", 256'(app_wdf_rdy), 256'd1);

    // Basic write
    axi.axi_awready = 1'b1;
    axi.axi_wready  = 1'b1;
    push_beat({32{8'hA5}}, 32'h0);
    do_write(27'h100, {32{8'hA5}}, 32'hFFFF_FFFF, 2'b00);
    check("err_clear", 256'(resp_err), 256'd0);
    app_cmd = APP_CMD_WR;
    #1 check("wr_rdy_empty", 256'(app_rdy), 256'd0);
    app_cmd = APP_CMD_RD;

    // Read with 5-cycle slave latency
    issue_cmd(APP_CMD_RD, 27'h40);
    check("arvalid_up", 256'(axi.axi_arvalid), 256'd1);
    check("araddr", 256'(axi.axi_araddr), 256'h40);
    check("arlen", 256'(axi.axi_arlen), 256'd0);
    check("rready_pre", 256'(axi.axi_rready), 256'd0);
    axi.axi_arready = 1'b1;
    @(negedge clock);
    axi.axi_arready = 1'b0;
    check("arvalid_drop", 256'(axi.axi_arvalid), 256'd0);
    check("rready_up", 256'(axi.axi_rready), 256'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rd_valid_wait", 256'(app_rd_data_valid), 256'd0);
    end
    axi.axi_rvalid = 1'b1;
    axi.axi_rdata  = {16{16'hDEAD}};
    axi.axi_rlast  = 1'b1;
    @(negedge clock);
    axi.axi_rvalid = 1'b0;
    axi.axi_rlast  = 1'b0;
    check("rd_valid", 256'(app_rd_data_valid), 256'd1);
    check("rd_end", 256'(app_rd_data_end), 256'd1);
    check("rd_data", app_rd_data, {16{16'hDEAD}});
    check("rready_drop", 256'(axi.axi_rready), 256'd0);
    @(negedge clock);
    check("rd_valid_pulse", 256'(app_rd_data_valid), 256'd0);

    // Illegal command is dropped
    issue_cmd(3'b011, 27'h10);
    check("illegal_aw", 256'(axi.axi_awvalid), 256'd0);
    check("illegal_ar", 256'(axi.axi_arvalid), 256'd0);
    check("illegal_rdy", 256'(app_rdy), 256'd1);

    // Data ahead of commands: fill the FIFO, extra beat must be refused
    for (int k = 0; k < 4; k++) begin
      d = {32{8'(8'h10 + k)}};
      m = 32'hFF << (8 * k);
      push_beat(d, m);
    end
    check("wdf_full", 256'(app_wdf_rdy), 256'd0);
    push_beat({32{8'hFF}}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      d = {32{8'(8'h10 + k)}};
      m = 32'hFF << (8 * k);
      do_write(27'(27'h200 + 16 * k), d, ~m, 2'b00);
    end
    app_cmd = APP_CMD_WR;
    #1 check("wdf_drained", 256'(app_rdy), 256'd0);
    check("wdf_rdy_again", 256'(app_wdf_rdy), 256'd1);
    app_cmd = APP_CMD_RD;

    // Decoupled AW/W: awready 3 cycles late, wready immediate
    push_beat({32{8'hC3}}, 32'h0);
    axi.axi_awready = 1'b0;
    axi.axi_wready  = 1'b1;
    issue_cmd(APP_CMD_WR, 27'h300);
    check("dec_aw_a", 256'(axi.axi_awvalid), 256'd1);
    check("dec_w_a", 256'(axi.axi_wvalid), 256'd1);
    @(negedge clock);
    check("dec_w_drop", 256'(axi.axi_wvalid), 256'd0);
    check("dec_aw_hold1", 256'(axi.axi_awvalid), 256'd1);
    check("dec_bready_early", 256'(axi.axi_bready), 256'd0);
    @(negedge clock);
    check("dec_aw_hold2", 256'(axi.axi_awvalid), 256'd1);
    axi.axi_awready = 1'b1;
    @(negedge clock);
    check("dec_aw_drop", 256'(axi.axi_awvalid), 256'd0);
    check("dec_bready", 256'(axi.axi_bready), 256'd1);
    axi.axi_bvalid = 1'b1;
    @(negedge clock);
    axi.axi_bvalid = 1'b0;
    check("dec_bready_drop", 256'(axi.axi_bready), 256'd0);
    check("dec_idle", 256'(app_rdy), 256'd1);

    // Sticky error response
    push_beat({32{8'h5A}}, 32'h0);
    do_write(27'h400, {32{8'h5A}}, 32'hFFFF_FFFF, 2'b10);
    check("err_set", 256'(resp_err), 256'd1);
    push_beat({32{8'h3C}}, 32'h0);
    do_write(27'h410, {32{8'h3C}}, 32'hFFFF_FFFF, 2'b00);
    check("err_sticky", 256'(resp_err), 256'd1);

    // Reset during RD_R
    axi.axi_arready = 1'b0;
    issue_cmd(APP_CMD_RD, 27'h80);
    axi.axi_arready = 1'b1;
    @(negedge clock);
    axi.axi_arready = 1'b0;
    check("mid_rready", 256'(axi.axi_rready), 256'd1);
    rst = 1'b1;
    #1;
    check("arst_rready", 256'(axi.axi_rready), 256'd0);
    check("arst_arvalid", 256'(axi.axi_arvalid), 256'd0);
    check("arst_awvalid", 256'(axi.axi_awvalid), 256'd0);
    check("arst_wvalid", 256'(axi.axi_wvalid), 256'd0);
    check("arst_bready", 256'(axi.axi_bready), 256'd0);
    check("arst_err", 256'(resp_err), 256'd0);
    check("arst_calib", 256'(init_calib_complete), 256'd0);
    axi.axi_rvalid = 1'b1;
    axi.axi_rdata  = {16{16'hDEAD}};
    @(negedge clock);
    axi.axi_rvalid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_stale_rd", 256'(app_rd_data_valid), 256'd0);
    end
    check("post_rst_rdy", 256'(app_rdy), 256'd1);
    app_cmd = APP_CMD_WR;
    #1 check("post_rst_fifo_empty", 256'(app_rdy), 256'd0);
    app_cmd = APP_CMD_RD;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
